// File: rtl/cms_trace_packer.sv
// Trace packer: captures PC, instruction and per-event counters per retired item, queues them and streams AXI-Stream beats.
// Optional macro CMS_PACKER_TIMESTAMP_EN packs a free-running 64-bit cycle stamp above the event counters.
module cms_trace_packer #(
  parameter int XLEN            = 64,
  parameter int INSTR_WIDTH     = 32,
  parameter int NUM_EVENTS      = 39,
  parameter int EVT_CNT_WIDTH   = 7,
  parameter int AXI_DATA_WIDTH  = 1024,
  parameter int FIFO_DEPTH      = 8,
  parameter int HALT_MARGIN     = 2,
  parameter int CTRL_ADDR_WIDTH = 8,
  parameter int CTRL_DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INSTR_WIDTH-1:0]     instr,
  input  logic [XLEN-1:0]            pc,
  input  logic                       pc_valid,
  input  logic [NUM_EVENTS-1:0]      performance_events,
  input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
  input  logic                       ctrl_write_enable,
  output logic                       M_AXIS_tvalid,
  input  logic                       M_AXIS_tready,
  output logic [AXI_DATA_WIDTH-1:0]  M_AXIS_tdata,
  output logic                       M_AXIS_tlast,
  output logic                       halt_cpu,
  output logic [1:0]                 state,
  output logic [63:0]                item_counter,
  output logic [31:0]                drop_counter
);

  localparam int EVT_W = NUM_EVENTS * EVT_CNT_WIDTH;
`ifdef CMS_PACKER_TIMESTAMP_EN
  localparam int TS_W = 64;
`else
  localparam int TS_W = 0;
`endif
  localparam int ITEM_W = INSTR_WIDTH + XLEN + EVT_W + TS_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  if (AXI_DATA_WIDTH < ITEM_W) begin : g_width_err
    $error("cms_trace_packer: AXI_DATA_WIDTH too small for packed item");
  end
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_err
    $error("cms_trace_packer: FIFO_DEPTH must be a power of 2 and >= 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUN     = 2'd2,
    ST_STOPPED = 2'd3
  } state_e;

  state_e                   state_r;
  logic                     we_prev_r;
  logic                     stop_en_r;
  logic [XLEN-1:0]          trig_pc_r;
  logic [XLEN-1:0]          stop_pc_r;
  logic [31:0]              tlast_interval_r;
  logic [31:0]              item_limit_r;
  logic [31:0]              run_count_r;
  logic [31:0]              frame_count_r;
  logic [EVT_CNT_WIDTH-1:0] evt_cnt_r [NUM_EVENTS];
  logic [EVT_CNT_WIDTH-1:0] evt_next_s [NUM_EVENTS];
  logic [ITEM_W:0]          mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [PTR_W:0]           count_r;
  logic [PTR_W:0]           count_next_s;
  logic [ITEM_W-1:0]        item_s;
  logic [ITEM_W:0]          head_s;
  logic [31:0]              interval_s;
  logic wr_s, ctrl_wr_s, clear_s, trig_hit_s, capture_s, final_s, frame_end_s;
  logic empty_s, full_s, push_s, pop_s;
`ifdef CMS_PACKER_TIMESTAMP_EN
  logic [63:0]              ts_r;
`endif

  assign wr_s        = ctrl_write_enable && !we_prev_r;
  assign ctrl_wr_s   = wr_s && (ctrl_addr == CTRL_ADDR_WIDTH'(0));
  assign clear_s     = ctrl_wr_s && ctrl_wdata[2];
  assign trig_hit_s  = (state_r == ST_ARMED) && pc_valid && (pc == trig_pc_r);
  assign capture_s   = pc_valid && ((state_r == ST_RUN) || trig_hit_s);
  assign final_s     = (stop_en_r && (pc == stop_pc_r)) ||
                       ((item_limit_r != 32'd0) && (run_count_r + 32'd1 == item_limit_r));
  assign interval_s  = (tlast_interval_r == 32'd0) ? 32'd1 : tlast_interval_r;
  assign frame_end_s = (frame_count_r == interval_s - 32'd1);

  assign empty_s      = (count_r == '0);
  assign full_s       = (count_r == (PTR_W+1)'(FIFO_DEPTH));
  assign pop_s        = !empty_s && M_AXIS_tready;
  assign push_s       = capture_s && (!full_s || pop_s);
  assign count_next_s = count_r + (PTR_W+1)'(push_s) - (PTR_W+1)'(pop_s);
  assign head_s       = mem_r[rd_ptr_r];

  assign M_AXIS_tvalid = !empty_s;
  assign M_AXIS_tdata  = empty_s ? '0 : AXI_DATA_WIDTH'(head_s[ITEM_W-1:0]);
  assign M_AXIS_tlast  = !empty_s && head_s[ITEM_W];
  assign state         = state_r;

  // Event counts including this cycle's pulses, and the packed item built from them
  always_comb begin
    item_s = '0;
    item_s[INSTR_WIDTH-1:0]       = instr;
    item_s[INSTR_WIDTH +: XLEN]   = pc;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      evt_next_s[i] = evt_cnt_r[i] +
        (((state_r != ST_IDLE) && performance_events[i]) ? EVT_CNT_WIDTH'(1) : EVT_CNT_WIDTH'(0));
      item_s[INSTR_WIDTH + XLEN + i*EVT_CNT_WIDTH +: EVT_CNT_WIDTH] = evt_next_s[i];
    end
`ifdef CMS_PACKER_TIMESTAMP_EN
    item_s[INSTR_WIDTH + XLEN + EVT_W +: 64] = ts_r;
`endif
  end

  // Control registers, written once per rising edge of the write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      we_prev_r        <= 1'b0;
      stop_en_r        <= 1'b0;
      trig_pc_r        <= '0;
      stop_pc_r        <= '0;
      tlast_interval_r <= 32'd1;
      item_limit_r     <= 32'd0;
    end else begin
      we_prev_r <= ctrl_write_enable;
      if (wr_s) begin
        case (ctrl_addr)
          CTRL_ADDR_WIDTH'(0): stop_en_r        <= ctrl_wdata[3];
          CTRL_ADDR_WIDTH'(1): trig_pc_r        <= XLEN'(ctrl_wdata);
          CTRL_ADDR_WIDTH'(2): stop_pc_r        <= XLEN'(ctrl_wdata);
          CTRL_ADDR_WIDTH'(3): tlast_interval_r <= ctrl_wdata[31:0];
          CTRL_ADDR_WIDTH'(4): item_limit_r     <= ctrl_wdata[31:0];
          default: ;
        endcase
      end
    end
  end

  // Capture state machine plus run/frame counters; a CTRL write overrides the normal transitions
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      run_count_r   <= 32'd0;
      frame_count_r <= 32'd0;
    end else begin
      if (ctrl_wr_s) begin
        state_r <= ctrl_wdata[0] ? (ctrl_wdata[1] ? ST_ARMED : ST_RUN) : ST_IDLE;
      end else begin
        case (state_r)
          ST_ARMED: if (trig_hit_s) state_r <= final_s ? ST_STOPPED : ST_RUN;
          ST_RUN:   if (capture_s && final_s) state_r <= ST_STOPPED;
          ST_IDLE, ST_STOPPED: state_r <= state_r;
          default:  state_r <= ST_IDLE;
        endcase
      end
      if (ctrl_wr_s && ctrl_wdata[0]) begin
        run_count_r   <= 32'd0;
        frame_count_r <= 32'd0;
      end else if (push_s) begin
        run_count_r   <= run_count_r + 32'd1;
        frame_count_r <= frame_end_s ? 32'd0 : frame_count_r + 32'd1;
      end
    end
  end

  // Per-event modulo counters, reloaded on every capture whether pushed or dropped
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (rst || clear_s || capture_s) evt_cnt_r[i] <= '0;
      else                             evt_cnt_r[i] <= evt_next_s[i];
    end
  end

  // FIFO storage; tlast is decided at push time and travels with the entry
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= {final_s || frame_end_s, item_s};
  end

  // FIFO pointers, almost-full halt and item/drop accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      halt_cpu     <= 1'b0;
      item_counter <= 64'd0;
      drop_counter <= 32'd0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r  <= count_next_s;
      halt_cpu <= (count_next_s >= (PTR_W+1)'(FIFO_DEPTH - HALT_MARGIN));
      if (clear_s) begin
        item_counter <= 64'd0;
        drop_counter <= 32'd0;
      end else begin
        if (push_s) item_counter <= item_counter + 64'd1;
        if (capture_s && !push_s && (drop_counter != 32'hFFFF_FFFF))
          drop_counter <= drop_counter + 32'd1;
      end
    end
  end

`ifdef CMS_PACKER_TIMESTAMP_EN
  // Free-running cycle stamp
  always_ff @(posedge clk) begin
    if (rst) ts_r <= 64'd0;
    else     ts_r <= ts_r + 64'd1;
  end
`endif

endmodule

// File: tb/tb_cms_trace_packer.sv
// Directed self-checking bench for cms_trace_packer with default parameters.
module tb_cms_trace_packer;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic [63:0]   pc;
  logic          pc_valid;
  logic [38:0]   performance_events;
  logic [7:0]    ctrl_addr;
  logic [63:0]   ctrl_wdata;
  logic          ctrl_write_enable;
  logic          M_AXIS_tvalid;
  logic          M_AXIS_tready;
  logic [1023:0] M_AXIS_tdata;
  logic          M_AXIS_tlast;
  logic          halt_cpu;
  logic [1:0]    state;
  logic [63:0]   item_counter;
  logic [31:0]   drop_counter;

  int errs = 0;
  int checks = 0;

  logic [63:0] beat_pc[$];
  logic [31:0] beat_instr[$];
  logic [6:0]  beat_ev0[$];
  logic        beat_last[$];

  cms_trace_packer dut (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc), .pc_valid(pc_valid),
    .performance_events(performance_events), .ctrl_addr(ctrl_addr),
    .ctrl_wdata(ctrl_wdata), .ctrl_write_enable(ctrl_write_enable),
    .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tlast(M_AXIS_tlast),
    .halt_cpu(halt_cpu), .state(state), .item_counter(item_counter),
    .drop_counter(drop_counter)
  );

  always #5 clk = ~clk;

  // Beat monitor: a beat transfers at the next rising edge when valid && ready
  always @(negedge clk) begin
    if (!rst && M_AXIS_tvalid && M_AXIS_tready) begin
      beat_pc.push_back(M_AXIS_tdata[32 +: 64]);
      beat_instr.push_back(M_AXIS_tdata[31:0]);
      beat_ev0.push_back(M_AXIS_tdata[96 +: 7]);
      beat_last.push_back(M_AXIS_tlast);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl_wr(input logic [7:0] a, input logic [63:0] d);
    ctrl_addr = a;
    ctrl_wdata = d;
    ctrl_write_enable = 1'b1;
    tick();
    ctrl_write_enable = 1'b0;
    tick();
  endtask

  task automatic item(input logic [63:0] p);
    pc = p;
    instr = 32'hA500_0000 | p[31:0];
    pc_valid = 1'b1;
    tick();
  endtask

  task automatic clear_beats();
    beat_pc.delete();
    beat_instr.delete();
    beat_ev0.delete();
    beat_last.delete();
  endtask

  initial begin
    rst = 1'b1;
    instr = 32'd0;
    pc = 64'd0;
    pc_valid = 1'b0;
    performance_events = 39'd0;
    ctrl_addr = 8'd0;
    ctrl_wdata = 64'd0;
    ctrl_write_enable = 1'b0;
    M_AXIS_tready = 1'b0;

    // Reset while every input toggles
    for (int i = 0; i < 6; i++) begin
      instr = $urandom;
      pc = {$urandom, $urandom};
      pc_valid = 1'(i);
      performance_events = {7'(i), $urandom};
      ctrl_addr = 8'(i % 5);
      ctrl_wdata = {$urandom, $urandom};
      ctrl_write_enable = 1'(i);
      M_AXIS_tready = 1'(i >> 1);
      tick();
    end
    check("rst_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    check("rst_tlast", 64'(M_AXIS_tlast), 64'd0);
    check("rst_tdata", 64'(|M_AXIS_tdata), 64'd0);
    check("rst_halt", 64'(halt_cpu), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_items", item_counter, 64'd0);
    check("rst_drops", 64'(drop_counter), 64'd0);
    pc_valid = 1'b0;
    performance_events = 39'd0;
    ctrl_write_enable = 1'b0;
    M_AXIS_tready = 1'b1;
    rst = 1'b0;
    tick();
    clear_beats();

    // Mode 0, interval 4, six items
    ctrl_wr(8'h03, 64'd4);
    ctrl_wr(8'h00, 64'h1);
    check("run_state", 64'(state), 64'd2);
    for (int i = 0; i < 6; i++) item(64'h1000 + 64'(4*i));
    pc_valid = 1'b0;
    repeat (3) tick();
    check("m0_beats", 64'(beat_pc.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < beat_pc.size()) begin
        check($sformatf("m0_pc%0d", i), beat_pc[i], 64'h1000 + 64'(4*i));
        check($sformatf("m0_last%0d", i), 64'(beat_last[i]), (i == 3) ? 64'd1 : 64'd0);
      end
    end
    if (beat_instr.size() > 2) check("m0_instr2", 64'(beat_instr[2]), 64'hA500_1008);
    check("m0_items", item_counter, 64'd6);
    check("m0_state", 64'(state), 64'd2);
    clear_beats();

    // Trigger / stop window
    ctrl_wr(8'h03, 64'd16);
    ctrl_wr(8'h01, 64'h2000);
    ctrl_wr(8'h02, 64'h2010);
    ctrl_wr(8'h00, 64'hB);
    check("trg_armed", 64'(state), 64'd1);
    item(64'h1FFC);
    check("trg_still_armed", 64'(state), 64'd1);
    item(64'h2000);
    check("trg_run", 64'(state), 64'd2);
    for (int i = 1; i < 6; i++) item(64'h2000 + 64'(4*i));
    pc_valid = 1'b0;
    repeat (3) tick();
    check("trg_stopped", 64'(state), 64'd3);
    check("trg_beats", 64'(beat_pc.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < beat_pc.size()) begin
        check($sformatf("trg_pc%0d", i), beat_pc[i], 64'h2000 + 64'(4*i));
        check($sformatf("trg_last%0d", i), 64'(beat_last[i]), (i == 4) ? 64'd1 : 64'd0);
      end
    end
    check("trg_items", item_counter, 64'd11);
    clear_beats();

    // Back-pressure: halt, drops, then an eight-cycle drain
    ctrl_wr(8'h00, 64'h5);
    check("clr_items", item_counter, 64'd0);
    M_AXIS_tready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      item(64'h3000 + 64'(4*(k-1)));
      check($sformatf("bp_halt%0d", k), 64'(halt_cpu), (k >= 6) ? 64'd1 : 64'd0);
    end
    pc_valid = 1'b0;
    tick();
    check("bp_drops", 64'(drop_counter), 64'd2);
    check("bp_items", item_counter, 64'd8);
    M_AXIS_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_valid%0d", i), 64'(M_AXIS_tvalid), 64'd1);
      check($sformatf("drain_pc%0d", i), M_AXIS_tdata[32 +: 64], 64'h3000 + 64'(4*i));
      tick();
    end
    check("drain_empty", 64'(M_AXIS_tvalid), 64'd0);
    check("drain_halt", 64'(halt_cpu), 64'd0);
    clear_beats();

    // 130 pulses on event 0, the last one coinciding with the capture
    for (int i = 0; i < 129; i++) begin
      performance_events = 39'd1;
      tick();
    end
    performance_events = 39'd1;
    item(64'h4000);
    performance_events = 39'd0;
    item(64'h4004);
    pc_valid = 1'b0;
    repeat (3) tick();
    check("ev_beats", 64'(beat_ev0.size()), 64'd2);
    if (beat_ev0.size() > 1) begin
      check("ev_wrap", 64'(beat_ev0[0]), 64'd2);
      check("ev_reload", 64'(beat_ev0[1]), 64'd0);
    end
    clear_beats();

    // Held strobe writes once: the later address/data change must be ignored
    ctrl_addr = 8'h03;
    ctrl_wdata = 64'd7;
    ctrl_write_enable = 1'b1;
    repeat (5) tick();
    ctrl_addr = 8'h00;
    ctrl_wdata = 64'd0;
    tick();
    check("hold_state", 64'(state), 64'd2);
    ctrl_write_enable = 1'b0;
    tick();
    ctrl_wr(8'h00, 64'h1);
    for (int i = 0; i < 8; i++) item(64'h5000 + 64'(4*i));
    pc_valid = 1'b0;
    repeat (3) tick();
    check("int7_beats", 64'(beat_last.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < beat_last.size())
        check($sformatf("int7_last%0d", i), 64'(beat_last[i]), (i == 6) ? 64'd1 : 64'd0);
    end
    clear_beats();

    // Reset mid-run with a non-empty FIFO
    M_AXIS_tready = 1'b0;
    for (int i = 0; i < 3; i++) item(64'h6000 + 64'(4*i));
    pc_valid = 1'b0;
    check("pre_rst_valid", 64'(M_AXIS_tvalid), 64'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 64'(M_AXIS_tvalid), 64'd0);
    check("mid_rst_tdata", 64'(|M_AXIS_tdata), 64'd0);
    check("mid_rst_tlast", 64'(M_AXIS_tlast), 64'd0);
    check("mid_rst_state", 64'(state), 64'd0);
    check("mid_rst_items", item_counter, 64'd0);
    check("mid_rst_halt", 64'(halt_cpu), 64'd0);
    rst = 1'b0;
    M_AXIS_tready = 1'b1;
    tick();
    clear_beats();
    ctrl_wr(8'h00, 64'h1);
    item(64'h7000);
    item(64'h7004);
    pc_valid = 1'b0;
    repeat (3) tick();
    check("def_int_beats", 64'(beat_last.size()), 64'd2);
    for (int i = 0; i < 2; i++) begin
      if (i < beat_last.size())
        check($sformatf("def_int_last%0d", i), 64'(beat_last[i]), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cms_trace_packer.md
Name: cms_trace_packer

Overview:
- Parametrised successor to the continuous monitoring system trace path.
- Captures per-instruction trace items: PC, instruction, and per-event modulo counters of events since the previous item.
- Buffers the items in an internal FIFO and streams them as AXI-Stream beats.
- Adds PC trigger/stop, an item limit, programmable tlast framing, drop accounting and almost-full CPU halt.

Parameters:
- XLEN, 64, PC width.
- INSTR_WIDTH, 32, instruction width.
- NUM_EVENTS, 39, number of performance event inputs.
- EVT_CNT_WIDTH, 7, width of each per-event modulo counter.
- AXI_DATA_WIDTH, 1024, width of M_AXIS_tdata; must be >= packed item width (elaboration error otherwise).
- FIFO_DEPTH, 8, FIFO entries; power of 2, >= 4.
- HALT_MARGIN, 2, free entries remaining at which halt_cpu asserts.
- CTRL_ADDR_WIDTH, 8, control address width.
- CTRL_DATA_WIDTH, 64, control data width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- instr  in  INSTR_WIDTH  instruction of the current item.
- pc  in  XLEN  PC of the current item.
- pc_valid  in  1  instr/pc retire this cycle.
- performance_events  in  NUM_EVENTS  one-cycle event pulses.
- ctrl_addr  in  CTRL_ADDR_WIDTH  register select.
- ctrl_wdata  in  CTRL_DATA_WIDTH  write data.
- ctrl_write_enable  in  1  write strobe, rising-edge triggered.
- M_AXIS_tvalid  out  1  FIFO head valid.
- M_AXIS_tready  in  1  sink ready.
- M_AXIS_tdata  out  AXI_DATA_WIDTH  packed item.
- M_AXIS_tlast  out  1  frame end.
- halt_cpu  out  1  FIFO almost full.
- state  out  2  0 IDLE, 1 ARMED, 2 RUN, 3 STOPPED.
- item_counter  out  64  items pushed since reset or clear.
- drop_counter  out  32  captures lost to a full FIFO, saturating.

Behaviour:
- Reset (rst=1 at a clk edge) clears everything: state=IDLE; all outputs 0; FIFO empty; event counters 0; all control registers to defaults.
- Register map, written when ctrl_write_enable=1 and its previous-cycle value=0; the write takes effect at that edge. A held strobe writes once.
  - 0x00 CTRL: bit0 enable; bit1 trigger_mode; bit2 clear (self-clearing; zeroes item_counter, drop_counter and event counters); bit3 stop_en. Default 0.
  - 0x01 TRIG_PC; default 0.
  - 0x02 STOP_PC; default 0.
  - 0x03 TLAST_INTERVAL, bits[31:0]; value 0 is treated as 1; default 1.
  - 0x04 ITEM_LIMIT, bits[31:0]; 0 = unlimited; default 0.
  - Other addresses are ignored.
- State machine transitions:
  - Write to CTRL with enable=1, from any state → ARMED if trigger_mode=1, else RUN. This also clears run_count and the frame counter.
  - Write to CTRL with enable=0, from any state → IDLE.
  - ARMED → RUN when pc_valid && pc==TRIG_PC; this item is captured.
  - RUN → STOPPED after capturing an item where (stop_en && pc==STOP_PC) or (ITEM_LIMIT!=0 && run_count+1==ITEM_LIMIT). That item carries tlast=1.
  - STOPPED ignores pc_valid.
- Capture: occurs when pc_valid and (state==RUN, or the ARMED trigger hit).
- Packed item, zero-filled above the last field:
  - instr at [INSTR_WIDTH-1:0];
  - pc next;
  - counter i at [INSTR_WIDTH+XLEN+i*EVT_CNT_WIDTH +: EVT_CNT_WIDTH].
- Event counters:
  - Increment mod 2^EVT_CNT_WIDTH on each event pulse, in all states except IDLE.
  - On capture, the packed value includes the current-cycle event; the counter then reloads to 0.
  - On a dropped capture the counter still reloads.
- FIFO push and drop:
  - A capture pushes when not full, or when full with a simultaneous pop.
  - Otherwise the capture is dropped: drop_counter+1, saturating.
  - Dropped captures do not advance run_count or the frame counter.
- tlast is computed at push and stored per entry: 1 if frame_count==TLAST_INTERVAL-1 (frame_count then wraps to 0) or the item is final (stop/limit).
- Stream outputs:
  - M_AXIS_tvalid = !empty.
  - tdata/tlast come from the head entry and are 0 when empty.
  - Pop on tvalid && tready.
  - Fall-through latency: push at edge N → tvalid high after edge N.
- halt_cpu is registered: 1 when occupancy >= FIFO_DEPTH-HALT_MARGIN after the edge.
- item_counter increments on each push, wrapping at 2^64.
- Disabling does not flush the FIFO; queued items still drain.

Optional Feature:
- Macro CMS_PACKER_TIMESTAMP_EN.
- When defined: a free-running 64-bit cycle counter (0 at reset, wraps) is sampled at capture and packed immediately above the last event counter; the elaboration width check includes it.
- When undefined: no counter exists and those bits are 0.

Test Plan:
- Reset with all inputs toggling → tvalid=0, tlast=0, tdata=0, halt_cpu=0, state=0, item_counter=0.
- Enable mode0, TLAST_INTERVAL=4, tready=1, six pc_valid items pc=0x1000..0x1014 step 4 → six beats in order; tlast=1 only on the 4th; item_counter=6; state=2.
- trigger_mode=1, stop_en=1, TRIG_PC=0x2000, STOP_PC=0x2010, pcs 0x1FFC..0x2014 → state 1→2→3; five beats pc 0x2000..0x2010; tlast=1 on the 0x2010 beat only.
- tready=0, FIFO_DEPTH=8, HALT_MARGIN=2, ten captures → halt_cpu=1 after the 6th push; captures 9 and 10 dropped (drop_counter=2); then tready=1 → eight beats in eight consecutive cycles.
- performance_events[0] pulsed 130 times between captures, including the capture cycle → counter 0 field = 2 (130 mod 128); next item field 0 if no further events.
- ctrl_write_enable held high 5 cycles at addr 0x03 data 7 → single write; rst asserted mid-RUN with FIFO non-empty → next cycle all outputs at reset values, TLAST_INTERVAL back to 1.
